move_sched: RTL and testbench
=============================

# move_sched

Command scheduler between the UART command path and `cmd_proc` in the KnightsTour design. It holds a queue of pre-loaded 16-bit move commands, such as a solved tour or a scripted L-move like 16'h43F2 followed by 16'h5001. It issues commands one at a time to `cmd_proc` and waits for each move to complete before issuing the next. Remote UART commands are arbitrated against the queue, and the 8'hA5 acknowledge is returned to the UART wrapper per UART command and once per drained queue.

## Interface
Parameters:
- DEPTH, 8, queue depth in entries; must be a power of 2, minimum 2.
- ACK, 8'hA5, acknowledge byte returned on completion.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock; all state updates on posedge.
  - rst_n  in  1  asynchronous active-low reset.
- UART command side:
  - uart_cmd  in  16  command from the UART wrapper.
  - uart_cmd_rdy  in  1  level; uart_cmd is valid.
  - clr_uart_rdy  out  1  one-cycle pulse; uart_cmd consumed.
- Queue side:
  - q_wdata  in  16  command to enqueue.
  - q_push  in  1  enqueue strobe.
  - q_go  in  1  pulse; start draining the queue.
  - q_full  out  1  count == DEPTH.
  - q_empty  out  1  count == 0.
  - q_cnt  out  $clog2(DEPTH)+1  current entry count.
  - q_ovf  out  1  sticky; a push was dropped.
- `cmd_proc` side:
  - cmd  out  16  command presented to `cmd_proc`.
  - cmd_rdy  out  1  level; cmd is valid.
  - clr_cmd_rdy  in  1  `cmd_proc` has taken cmd.
  - send_resp  in  1  pulse; move complete.
- Response side:
  - resp  out  8  response byte.
  - resp_vld  out  1  one-cycle pulse; resp is valid.
- Status:
  - busy  out  1  high in any state other than IDLE.

## Operation
- Queue: circular FIFO with write pointer, read pointer and count.
  - Push when full is dropped and sets q_ovf; q_ovf clears only on reset.
  - Push and pop in the same cycle leave count unchanged. This is legal even when full: the push is accepted and q_ovf is not set.
- run flag:
  - Set by q_go when !q_empty.
  - q_go while q_empty is ignored.
  - q_go while run is already set has no effect.
- FSM states are IDLE, ISSUE, WAIT_DONE and ACK.
- IDLE:
  - If uart_cmd_rdy: load cmd from uart_cmd, pulse clr_uart_rdy, set src=UART, go to ISSUE.
  - Else if run && !q_empty: pop the head into cmd, set src=Q, go to ISSUE.
  - UART always has priority over the queue in IDLE. A UART command arriving mid-move waits; clr_uart_rdy is not pulsed until it is granted.
- ISSUE:
  - cmd_rdy is held high.
  - On clr_cmd_rdy, drop cmd_rdy and go to WAIT_DONE.
  - cmd holds its value until the next load.
- WAIT_DONE:
  - On send_resp, go to ACK if src=UART or (src=Q and q_empty). Otherwise go to IDLE.
  - send_resp is ignored in every state except WAIT_DONE.
- ACK:
  - Pulse resp_vld with resp=ACK, then go to IDLE.
  - If src=Q, clear run.
- Queue commands other than the last produce no acknowledge.
- Pushes during draining are allowed. If the queue is non-empty at completion, draining continues.

## Timing
- Reset values: cmd=0, cmd_rdy=0, clr_uart_rdy=0, resp=0, resp_vld=0, busy=0, q_cnt=0, q_empty=1, q_full=0, q_ovf=0. State is IDLE, run=0, and pointers are 0.
- All outputs are registered.
- UART grant: uart_cmd_rdy is sampled high in IDLE at edge N. cmd, cmd_rdy and clr_uart_rdy are all high after edge N; clr_uart_rdy lasts exactly one cycle.
- Queue issue: cmd and cmd_rdy are valid 1 cycle after the IDLE edge where the pop occurs. q_cnt decrements on the same edge.
- If clr_cmd_rdy is sampled at edge M, cmd_rdy is low after edge M.
- If send_resp is sampled at edge K, resp_vld is high for the cycle after edge K (1-cycle latency).
- Minimum gap between consecutive queue issues is 2 cycles after send_resp: WAIT_DONE→IDLE, then IDLE→ISSUE.
- Reset asserted mid-operation: immediate return to reset values, queue contents discarded, no acknowledge emitted.
- q_cnt, q_full and q_empty update on the edge after a push or pop.

## Test plan
- Reset mid-move (in WAIT_DONE with 3 entries queued) → all outputs at reset values, q_empty=1; a subsequent send_resp produces no resp_vld.
- Single UART cmd:
  - Stimulus: uart_cmd=16'h2000 with uart_cmd_rdy, then clr_cmd_rdy, then send_resp after 50 cycles.
  - Required response: cmd=16'h2000 with cmd_rdy and a one-cycle clr_uart_rdy; then resp=8'hA5 with resp_vld, 1 cycle after send_resp.
- Queue drain:
  - Stimulus: push 16'h43F2 and 16'h5001, pulse q_go, then model clr_cmd_rdy and send_resp for each command.
  - Required response: the two cmds are issued in order and exactly one resp_vld (8'hA5) follows the second send_resp; run clears and busy=0.
- Arbitration: the queue holds 2 entries and is running; uart_cmd=16'h0000 is asserted during the first move → the UART cmd is issued before the second queue entry. The UART cmd receives its own 8'hA5, and the queue's 8'hA5 follows its last entry, for 2 resp_vld total.
- Full/overflow with DEPTH=8:
  - Stimulus: push 9 commands.
  - Required response: q_full=1, q_cnt=8, q_ovf=1 and the 9th push is dropped.
  - Then push and pop in the same cycle while full → q_cnt stays 8.
- q_go while empty → run remains 0 and no cmd_rdy appears; stray send_resp pulses while in IDLE produce no resp_vld.

Source files
------------

// File: rtl/move_sched.sv
// Purpose : schedules 16-bit move commands to cmd_proc from a pre-loaded queue or the UART path, returning ACK bytes.
// Latency : command issued 1 cycle after grant/pop; ACK byte 1 cycle after send_resp of the acknowledged move.
// Backpress: one move in flight; UART waits (no clr_uart_rdy) until granted; pushes to a full queue are dropped (q_ovf).
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   uart_cmd/uart_cmd_rdy/clr_uart_rdy  UART command handshake (rdy is a level, clr is a 1-cycle pulse)
//   q_wdata/q_push/q_go              enqueue data/strobe, start-drain pulse
//   q_full/q_empty/q_cnt/q_ovf       queue status (q_ovf sticky until reset)
//   cmd/cmd_rdy/clr_cmd_rdy/send_resp  cmd_proc handshake and move-complete pulse
//   resp/resp_vld                    acknowledge byte and its 1-cycle strobe
//   busy                             FSM not in IDLE
module move_sched #(
    parameter int          DEPTH = 8,
    parameter logic [7:0]  ACK   = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              uart_cmd,
    input  logic                     uart_cmd_rdy,
    output logic                     clr_uart_rdy,
    input  logic [15:0]              q_wdata,
    input  logic                     q_push,
    input  logic                     q_go,
    output logic                     q_full,
    output logic                     q_empty,
    output logic [$clog2(DEPTH):0]   q_cnt,
    output logic                     q_ovf,
    output logic [15:0]              cmd,
    output logic                     cmd_rdy,
    input  logic                     clr_cmd_rdy,
    input  logic                     send_resp,
    output logic [7:0]               resp,
    output logic                     resp_vld,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        ACK_ST    = 2'd3
    } state_t;

    state_t          state;
    logic            run;
    logic            src_q;     // 1: current move came from the queue, 0: from UART
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [15:0]     mem [DEPTH];

    logic            pop;
    logic            push_ok;
    logic [CW-1:0]   cnt_nxt;

    // The queue is only popped from IDLE when UART is not requesting, so
    // UART always wins arbitration.
    assign pop     = (state == IDLE) && !uart_cmd_rdy && run && !q_empty;
    // A pop in the same cycle frees the slot, so a push to a full queue is
    // still accepted then.
    assign push_ok = q_push && (!q_full || pop);

    always_comb begin
        cnt_nxt = q_cnt;
        if (push_ok && !pop)
            cnt_nxt = q_cnt + CW'(1);
        else if (pop && !push_ok)
            cnt_nxt = q_cnt - CW'(1);
    end

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= q_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            run          <= 1'b0;
            src_q        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            q_cnt        <= '0;
            q_full       <= 1'b0;
            q_empty      <= 1'b1;
            q_ovf        <= 1'b0;
            cmd          <= '0;
            cmd_rdy      <= 1'b0;
            clr_uart_rdy <= 1'b0;
            resp         <= '0;
            resp_vld     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            clr_uart_rdy <= 1'b0;
            resp_vld     <= 1'b0;

            // Queue bookkeeping
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (q_push && !push_ok)
                q_ovf <= 1'b1;
            q_cnt   <= cnt_nxt;
            q_full  <= (cnt_nxt == CW'(DEPTH));
            q_empty <= (cnt_nxt == '0);

            // The end-of-drain clear takes precedence: q_go while running
            // has no effect.
            if (state == ACK_ST && src_q)
                run <= 1'b0;
            else if (q_go && !q_empty)
                run <= 1'b1;

            case (state)
                IDLE: begin
                    if (uart_cmd_rdy) begin
                        cmd          <= uart_cmd;
                        cmd_rdy      <= 1'b1;
                        clr_uart_rdy <= 1'b1;
                        src_q        <= 1'b0;
                        state        <= ISSUE;
                        busy         <= 1'b1;
                    end else if (pop) begin
                        cmd     <= mem[rd_ptr];
                        cmd_rdy <= 1'b1;
                        src_q   <= 1'b1;
                        state   <= ISSUE;
                        busy    <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (clr_cmd_rdy) begin
                        cmd_rdy <= 1'b0;
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (send_resp) begin
                        // Queue moves are only acknowledged once the queue
                        // has drained; otherwise keep draining via IDLE.
                        if (!src_q || q_empty) begin
                            state    <= ACK_ST;
                            resp     <= ACK;
                            resp_vld <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ACK_ST: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sched.sv
// Purpose : directed self-checking bench for move_sched (queue table plus hand sequences).
// Latency : checks sampled 1 time unit after each rising edge.
// Backpress: bench models the UART wrapper (drops uart_cmd_rdy on clr_uart_rdy) and cmd_proc handshakes.
module tb_move_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] uart_cmd = '0;
    logic        uart_cmd_rdy = 1'b0;
    logic        clr_uart_rdy;
    logic [15:0] q_wdata = '0;
    logic        q_push = 1'b0;
    logic        q_go = 1'b0;
    logic        q_full;
    logic        q_empty;
    logic [3:0]  q_cnt;
    logic        q_ovf;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;
    logic        resp_vld;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int resp_seen = 0;

    move_sched #(.DEPTH(8), .ACK(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_cmd     (uart_cmd),
        .uart_cmd_rdy (uart_cmd_rdy),
        .clr_uart_rdy (clr_uart_rdy),
        .q_wdata      (q_wdata),
        .q_push       (q_push),
        .q_go         (q_go),
        .q_full       (q_full),
        .q_empty      (q_empty),
        .q_cnt        (q_cnt),
        .q_ovf        (q_ovf),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp),
        .resp_vld     (resp_vld),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [15:0] wdata;
        logic        go;
        logic [3:0]  e_cnt;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
        logic        e_rdy;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample 1 unit after the edge, model the UART wrapper and
    // count acknowledge strobes.
    task automatic step();
        @(posedge clk);
        #1;
        if (clr_uart_rdy)
            uart_cmd_rdy = 1'b0;
        if (resp_vld)
            resp_seen++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".cmd"},          32'(cmd),          32'h0);
        chk({tag, ".cmd_rdy"},      32'(cmd_rdy),      32'h0);
        chk({tag, ".clr_uart_rdy"}, 32'(clr_uart_rdy), 32'h0);
        chk({tag, ".resp"},         32'(resp),         32'h0);
        chk({tag, ".resp_vld"},     32'(resp_vld),     32'h0);
        chk({tag, ".busy"},         32'(busy),         32'h0);
        chk({tag, ".q_cnt"},        32'(q_cnt),        32'h0);
        chk({tag, ".q_empty"},      32'(q_empty),      32'h1);
        chk({tag, ".q_full"},       32'(q_full),       32'h0);
        chk({tag, ".q_ovf"},        32'(q_ovf),        32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        uart_cmd_rdy = 1'b0; q_push = 1'b0; q_go = 1'b0;
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [15:0] d);
        q_wdata = d; q_push = 1'b1;
        step();
        q_push = 1'b0;
    endtask

    // Serve one move as cmd_proc: wait for cmd_rdy, take it, complete after
    // 'dly' cycles and check whether an acknowledge follows.
    task automatic serve(input logic [15:0] exp_cmd, input logic exp_ack, input int dly);
        int n = 0;
        while (!cmd_rdy && n < 20) begin
            step();
            n++;
        end
        chk("serve.cmd_rdy_seen", 32'(cmd_rdy), 32'h1);
        chk("serve.cmd", 32'(cmd), 32'(exp_cmd));
        chk("serve.busy", 32'(busy), 32'h1);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        chk("serve.cmd_rdy_drop", 32'(cmd_rdy), 32'h0);
        repeat (dly) step();
        chk("serve.no_early_resp", 32'(resp_vld), 32'h0);
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        chk("serve.resp_vld", 32'(resp_vld), 32'(exp_ack));
        if (exp_ack)
            chk("serve.resp", 32'(resp), 32'hA5);
        step();
        chk("serve.resp_pulse_end", 32'(resp_vld), 32'h0);
    endtask

    initial begin
        // Fill / overflow table: cnt, full, empty, ovf, cmd_rdy after each edge.
        tbl[0] = '{1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b1, 16'h1000 + 16'(i), 1'b0, 4'(i), (i == 8), 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 16'hBEEF, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1};  // push+pop while full
        tbl[11] = '{1'b1, 16'hDEAD, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1};  // dropped push

        do_reset();

        // ---- full / overflow ----
        for (int i = 0; i < 12; i++) begin
            q_push = tbl[i].push; q_wdata = tbl[i].wdata; q_go = tbl[i].go;
            step();
            q_push = 1'b0; q_go = 1'b0;
            chk($sformatf("tbl%0d.q_cnt", i),   32'(q_cnt),   32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.q_full", i),  32'(q_full),  32'(tbl[i].e_full));
            chk($sformatf("tbl%0d.q_empty", i), 32'(q_empty), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d.q_ovf", i),   32'(q_ovf),   32'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d.cmd_rdy", i), 32'(cmd_rdy), 32'(tbl[i].e_rdy));
        end
        // Drain: 1001..1008 then BEEF, DEAD never appears, one ACK at the end.
        resp_seen = 0;
        for (int i = 1; i <= 8; i++)
            serve(16'h1000 + 16'(i), 1'b0, 1);
        serve(16'hBEEF, 1'b1, 1);
        chk("ovf.resp_count", 32'(resp_seen), 32'd1);
        chk("ovf.busy_end", 32'(busy), 32'h0);
        chk("ovf.empty_end", 32'(q_empty), 32'h1);
        chk("ovf.sticky", 32'(q_ovf), 32'h1);
        // run cleared: a new entry is not issued without q_go
        push(16'h7777);
        repeat (4) step();
        chk("ovf.run_cleared", 32'(cmd_rdy), 32'h0);

        // ---- q_go while empty, stray send_resp ----
        do_reset();
        q_go = 1'b1;
        step();
        q_go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_resp = 1'b1;
            step();
            send_resp = 1'b0;
            chk($sformatf("empty_go.cmd_rdy%0d", i), 32'(cmd_rdy), 32'h0);
            chk($sformatf("empty_go.resp_vld%0d", i), 32'(resp_vld), 32'h0);
        end
        push(16'h1234);
        repeat (3) step();
        chk("empty_go.run_stays0", 32'(cmd_rdy), 32'h0);
        q_go = 1'b1;
        step();
        q_go = 1'b0;
        chk("empty_go.no_pop_yet", 32'(cmd_rdy), 32'h0);
        step();
        chk("empty_go.pop_issue", 32'(cmd_rdy), 32'h1);
        chk("empty_go.pop_cmd", 32'(cmd), 32'h1234);
        chk("empty_go.pop_cnt", 32'(q_cnt), 32'h0);

        // ---- single UART command ----
        do_reset();
        resp_seen = 0;
        uart_cmd = 16'h2000; uart_cmd_rdy = 1'b1;
        step();
        chk("uart.cmd", 32'(cmd), 32'h2000);
        chk("uart.cmd_rdy", 32'(cmd_rdy), 32'h1);
        chk("uart.clr_uart_rdy", 32'(clr_uart_rdy), 32'h1);
        step();
        chk("uart.clr_uart_pulse", 32'(clr_uart_rdy), 32'h0);
        serve(16'h2000, 1'b1, 50);
        chk("uart.busy_end", 32'(busy), 32'h0);
        chk("uart.resp_count", 32'(resp_seen), 32'd1);

        // ---- queue drain ----
        do_reset();
        resp_seen = 0;
        push(16'h43F2);
        push(16'h5001);
        q_go = 1'b1;
        step();
        q_go = 1'b0;
        serve(16'h43F2, 1'b0, 3);
        serve(16'h5001, 1'b1, 3);
        chk("drain.busy_end", 32'(busy), 32'h0);
        chk("drain.resp_count", 32'(resp_seen), 32'd1);

        // ---- arbitration ----
        do_reset();
        resp_seen = 0;
        push(16'h0A01);
        push(16'h0A02);
        q_go = 1'b1;
        step();
        q_go = 1'b0;
        step();
        chk("arb.first_cmd", 32'(cmd), 32'h0A01);
        chk("arb.first_rdy", 32'(cmd_rdy), 32'h1);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        uart_cmd = 16'h0000; uart_cmd_rdy = 1'b1;
        repeat (5) begin
            step();
            chk("arb.uart_held", 32'(clr_uart_rdy), 32'h0);
        end
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        chk("arb.no_ack_first", 32'(resp_vld), 32'h0);
        step();
        chk("arb.uart_grant", 32'(clr_uart_rdy), 32'h1);
        serve(16'h0000, 1'b1, 3);
        serve(16'h0A02, 1'b1, 3);
        chk("arb.resp_count", 32'(resp_seen), 32'd2);
        chk("arb.busy_end", 32'(busy), 32'h0);

        // ---- reset mid-move ----
        do_reset();
        resp_seen = 0;
        for (int i = 0; i < 4; i++)
            push(16'hC000 + 16'(i));
        q_go = 1'b1;
        step();
        q_go = 1'b0;
        step();
        chk("rstmid.cmd", 32'(cmd), 32'hC000);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        chk("rstmid.cnt3", 32'(q_cnt), 32'd3);
        chk("rstmid.busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        chk("rstmid.no_resp", 32'(resp_vld), 32'h0);
        repeat (3) step();
        chk("rstmid.resp_count", 32'(resp_seen), 32'd0);
        chk("rstmid.idle", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
